// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter: digit type and active-low
// seven-segment codes (bit 0 = segment a ... bit 6 = segment g).
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with a
// blanking input; codes 10..15 decode to all segments off.
module seg7_bcd_decode
    import bcd_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit up/down BCD event counter (00..WRAP_AT) with synchronous clear,
// wrap pulse for cascading and registered seven-segment drive.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int WRAP_AT    = 99,
    parameter int BLANK_LEAD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       clr,
    output bcd_t       ones,
    output bcd_t       tens,
    output logic       wrap_tick,
    output logic [6:0] hex0,
    output logic [6:0] hex1
);

    localparam bcd_t       WRAP_TENS = bcd_t'(WRAP_AT / 10);
    localparam bcd_t       WRAP_ONES = bcd_t'(WRAP_AT % 10);
    localparam logic [6:0] HEX1_RST  = (BLANK_LEAD != 0) ? SEG_BLANK : SEG_0;

    bcd_t       ones_next;
    bcd_t       tens_next;
    logic       wrap_next;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic       tens_blank;

    always_comb begin
        ones_next = ones;
        tens_next = tens;
        wrap_next = 1'b0;
        if (clr) begin
            ones_next = 4'd0;
            tens_next = 4'd0;
        end else if (en) begin
            if (dir) begin
                if (tens == WRAP_TENS && ones == WRAP_ONES) begin
                    ones_next = 4'd0;
                    tens_next = 4'd0;
                    wrap_next = 1'b1;
                end else if (ones == 4'd9) begin
                    ones_next = 4'd0;
                    tens_next = tens + 4'd1;
                end else begin
                    ones_next = ones + 4'd1;
                end
            end else begin
                if (tens == 4'd0 && ones == 4'd0) begin
                    ones_next = WRAP_ONES;
                    tens_next = WRAP_TENS;
                    wrap_next = 1'b1;
                end else if (ones == 4'd0) begin
                    ones_next = 4'd9;
                    tens_next = tens - 4'd1;
                end else begin
                    ones_next = ones - 4'd1;
                end
            end
        end
    end

    // Segments decode the registered count, so they trail it by one cycle.
    assign tens_blank = (BLANK_LEAD != 0) && (tens == 4'd0);

    seg7_bcd_decode u_dec_ones (
        .digit (ones),
        .blank (1'b0),
        .seg   (seg_ones)
    );

    seg7_bcd_decode u_dec_tens (
        .digit (tens),
        .blank (tens_blank),
        .seg   (seg_tens)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones      <= 4'd0;
            tens      <= 4'd0;
            wrap_tick <= 1'b0;
            hex0      <= SEG_0;
            hex1      <= HEX1_RST;
        end else begin
            ones      <= ones_next;
            tens      <= tens_next;
            wrap_tick <= wrap_next;
            hex0      <= seg_ones;
            hex1      <= seg_tens;
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: default instance (99, blanking) and a
// 0..59 instance with leading zeros, both checked against hand values.
module tb_bcd_tick_counter;

    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en_a = 1'b0, dir_a = 1'b1, clr_a = 1'b0;
    logic       en_b = 1'b0, dir_b = 1'b1, clr_b = 1'b0;
    logic [3:0] ones_a, tens_a, ones_b, tens_b;
    logic       wrap_a, wrap_b;
    logic [6:0] hex0_a, hex1_a, hex0_b, hex1_b;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    int errors = 0;
    int checks = 0;
    int va = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    bcd_tick_counter dut_a (
        .clk (clk), .reset (reset), .en (en_a), .dir (dir_a), .clr (clr_a),
        .ones (ones_a), .tens (tens_a), .wrap_tick (wrap_a),
        .hex0 (hex0_a), .hex1 (hex1_a)
    );

    bcd_tick_counter #(.WRAP_AT (59), .BLANK_LEAD (0)) dut_b (
        .clk (clk), .reset (reset), .en (en_b), .dir (dir_b), .clr (clr_b),
        .ones (ones_b), .tens (tens_b), .wrap_tick (wrap_b),
        .hex0 (hex0_b), .hex1 (hex1_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle request on dut_a; returns at the negedge after the sampling edge.
    task automatic step_a(input logic e, input logic d, input logic c);
        @(negedge clk);
        en_a = e; dir_a = d; clr_a = c;
        @(negedge clk);
        en_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic check_count_a(input string tag, input int v, input logic w);
        check({tag, ".ones"}, 16'(ones_a), 16'(v % 10));
        check({tag, ".tens"}, 16'(tens_a), 16'(v / 10));
        check({tag, ".wrap"}, 16'(wrap_a), 16'(w));
    endtask

    task automatic check_hex_a(input string tag, input int v);
        check({tag, ".hex0"}, 16'(hex0_a), 16'(seg_tab[v % 10]));
        check({tag, ".hex1"}, 16'(hex1_a), 16'((v / 10 == 0) ? BLANK : seg_tab[v / 10]));
    endtask

    // Digits must stay BCD on every cycle.
    always @(negedge clk) begin
        if (!done) begin
            check("bcd_range_a", 16'(ones_a <= 4'd9 && tens_a <= 4'd9), 16'd1);
            check("bcd_range_b", 16'(ones_b <= 4'd9 && tens_b <= 4'd9), 16'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state while asserted
        #12;
        check_count_a("rst", 0, 1'b0);
        check("rst.hex0", 16'(hex0_a), 16'(7'b1000000));
        check("rst.hex1", 16'(hex1_a), 16'(BLANK));
        check("rst_b.hex1", 16'(hex1_b), 16'(7'b1000000));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_count_a("hold_after_rst", 0, 1'b0);

        // Latency: count one cycle after en, segments two cycles after
        step_a(1'b1, 1'b1, 1'b0);
        check_count_a("lat_1cyc", 1, 1'b0);
        check("lat_1cyc.hex0_old", 16'(hex0_a), 16'(7'b1000000));
        @(negedge clk);
        check("lat_2cyc.hex0", 16'(hex0_a), 16'(7'b1111001));

        step_a(1'b0, 1'b0, 1'b1);
        va = 0;
        check_count_a("clr", 0, 1'b0);

        // 100 up pulses through 09->10 and 99->00
        for (int i = 1; i <= 100; i++) begin
            step_a(1'b1, 1'b1, 1'b0);
            va = (va == 99) ? 0 : va + 1;
            check_count_a($sformatf("up%0d", i), va, (i == 100));
            @(negedge clk);
            check($sformatf("up%0d.wrap_gone", i), 16'(wrap_a), 16'd0);
            check_hex_a($sformatf("up%0d", i), va);
            if (va == 10) check("up_ten.hex1", 16'(hex1_a), 16'(7'b1111001));
        end

        // Down wrap 00 -> 99 -> 98
        step_a(1'b1, 1'b0, 1'b0);
        check_count_a("down_wrap", 99, 1'b1);
        step_a(1'b1, 1'b0, 1'b0);
        check_count_a("down_98", 98, 1'b0);

        // 10 -> 09 borrow
        step_a(1'b0, 1'b0, 1'b1);
        repeat (10) step_a(1'b1, 1'b1, 1'b0);
        check_count_a("at10", 10, 1'b0);
        step_a(1'b1, 1'b0, 1'b0);
        check_count_a("borrow_09", 9, 1'b0);
        @(negedge clk);
        check_hex_a("borrow_09", 9);

        // clr beats en at the wrap point
        step_a(1'b0, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 1'b0);
        check_count_a("to99", 99, 1'b1);
        step_a(1'b1, 1'b1, 1'b1);
        check_count_a("clr_over_en", 0, 1'b0);

        // Asynchronous reset mid-count at 47
        repeat (47) step_a(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_count_a("at47", 47, 1'b0);
        #3 reset = 1'b0;
        #1;
        check_count_a("async_rst", 0, 1'b0);
        check("async_rst.hex0", 16'(hex0_a), 16'(7'b1000000));
        check("async_rst.hex1", 16'(hex1_a), 16'(BLANK));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_count_a("rst_release_hold", 0, 1'b0);
        check_hex_a("rst_release_hold", 0);

        // WRAP_AT=59: en held for 60 cycles
        en_b = 1'b1; dir_b = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 60) en_b = 1'b0;
            check($sformatf("b_held%0d.ones", k), 16'(ones_b), 16'((k % 60) % 10));
            check($sformatf("b_held%0d.tens", k), 16'(tens_b), 16'((k % 60) / 10));
            check($sformatf("b_held%0d.wrap", k), 16'(wrap_b), 16'(k == 60));
        end
        repeat (5) begin
            @(negedge clk);
            en_b = 1'b1;
            @(negedge clk);
            en_b = 1'b0;
        end
        @(negedge clk);
        check("b_05.ones", 16'(ones_b), 16'd5);
        check("b_05.hex0", 16'(hex0_b), 16'(7'b0010010));
        check("b_05.hex1", 16'(hex1_b), 16'(7'b1000000));

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
